// File: rtl/pc_sequencer_if.sv
// Fetch-side bus bundle for pc_sequencer: redirect input, next-PC mux operands,
// instruction-memory req/ack and the decode valid/ready handshake. addr_err exists only with ALIGN_CHECK_EN.
interface pc_sequencer_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus_four;
  logic [31:0] jump_amount;
  logic        select;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef ALIGN_CHECK_EN
  logic        addr_err;
`endif

  modport master (
    input  redirect_valid, redirect_target, imem_ack, imem_rdata, instr_ready,
`ifdef ALIGN_CHECK_EN
    output addr_err,
`endif
    output pc_plus_four, jump_amount, select, pc, imem_req, imem_addr,
    output instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_target, imem_ack, imem_rdata, instr_ready,
`ifdef ALIGN_CHECK_EN
    input  addr_err,
`endif
    input  pc_plus_four, jump_amount, select, pc, imem_req, imem_addr,
    input  instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE -> FETCH -> DELIVER loop with redirect/flush handling.
// Optional ALIGN_CHECK_EN sends misaligned redirects to EXC_VECTOR and pulses addr_err.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef ALIGN_CHECK_EN
  , parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
`endif
) (
  input logic          clk,
  input logic          rst,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2
  } seqStateT;

  seqStateT    stateR, nextStateS;
  logic        flushR, flushNextS;
  logic [31:0] pcNextS, addrNextS, instrNextS, instrPcNextS;
  logic        reqNextS, validNextS;
  logic [31:0] loadTargetS, updPcS;

  assign bus.pc_plus_four = bus.pc + 32'd4;
  assign bus.jump_amount  = bus.redirect_target;
  assign bus.select       = bus.redirect_valid;

`ifdef ALIGN_CHECK_EN
  logic misalignS;
  assign misalignS   = (bus.jump_amount[1:0] != 2'b00);
  assign loadTargetS = misalignS ? EXC_VECTOR : bus.jump_amount;
`else
  assign loadTargetS = {bus.jump_amount[31:2], 2'b00};
`endif

  // PC after this cycle's redirect, before any sequential step
  assign updPcS = bus.select ? loadTargetS : bus.pc;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR          <= IDLE;
      flushR          <= 1'b0;
      bus.pc          <= RESET_PC;
      bus.imem_req    <= 1'b0;
      bus.imem_addr   <= 32'h0000_0000;
      bus.instr_valid <= 1'b0;
      bus.instr       <= 32'h0000_0000;
      bus.instr_pc    <= 32'h0000_0000;
`ifdef ALIGN_CHECK_EN
      bus.addr_err    <= 1'b0;
`endif
    end else begin
      stateR          <= nextStateS;
      flushR          <= flushNextS;
      bus.pc          <= pcNextS;
      bus.imem_req    <= reqNextS;
      bus.imem_addr   <= addrNextS;
      bus.instr_valid <= validNextS;
      bus.instr       <= instrNextS;
      bus.instr_pc    <= instrPcNextS;
`ifdef ALIGN_CHECK_EN
      bus.addr_err    <= bus.select && misalignS;
`endif
    end
  end

  // Next-state decode
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      IDLE: nextStateS = FETCH;
      FETCH: begin
        if (bus.imem_ack && !flushR && !bus.select) nextStateS = DELIVER;
        else nextStateS = FETCH;
      end
      DELIVER: begin
        if (bus.select || bus.instr_ready) nextStateS = FETCH;
        else nextStateS = DELIVER;
      end
      default: nextStateS = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    pcNextS      = bus.pc;
    reqNextS     = bus.imem_req;
    addrNextS    = bus.imem_addr;
    validNextS   = bus.instr_valid;
    instrNextS   = bus.instr;
    instrPcNextS = bus.instr_pc;
    flushNextS   = flushR;
    case (stateR)
      IDLE: begin
        pcNextS   = updPcS;
        reqNextS  = 1'b1;
        addrNextS = updPcS;
      end
      FETCH: begin
        pcNextS = updPcS;
        if (bus.imem_ack) begin
          if (flushR || bus.select) begin
            // stale or redirected data: drop it and re-request from the live PC
            flushNextS = 1'b0;
            addrNextS  = updPcS;
            reqNextS   = 1'b1;
          end else begin
            instrNextS   = bus.imem_rdata;
            instrPcNextS = bus.imem_addr;
            validNextS   = 1'b1;
            reqNextS     = 1'b0;
          end
        end else if (bus.select) begin
          flushNextS = 1'b1;
        end else begin
          flushNextS = flushR;
        end
      end
      DELIVER: begin
        if (bus.select) begin
          pcNextS    = loadTargetS;
          addrNextS  = loadTargetS;
          validNextS = 1'b0;
          reqNextS   = 1'b1;
        end else if (bus.instr_ready) begin
          pcNextS    = bus.pc_plus_four;
          addrNextS  = bus.pc_plus_four;
          validNextS = 1'b0;
          reqNextS   = 1'b1;
        end else begin
          validNextS = 1'b1;
        end
      end
      default: begin
        pcNextS    = RESET_PC;
        reqNextS   = 1'b0;
        addrNextS  = 32'h0000_0000;
        validNextS = 1'b0;
        flushNextS = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written corner
// sequences, then randomized traffic checked against a transaction-level PC model.
module tb_pc_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  pc_sequencer_if bus();
  pc_sequencer #(.RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // memory always answers with the word for the address currently requested
  assign bus.imem_rdata = memWord(bus.imem_addr);

  function automatic logic [31:0] loadModel(input logic [31:0] t);
`ifdef ALIGN_CHECK_EN
    return (t % 32'd4 != 32'd0) ? 32'h0000_0080 : t;
`else
    return t - (t % 32'd4);
`endif
  endfunction

  typedef struct {
    logic        redir;
    logic [31:0] target;
    logic        ready;
    logic        ack;
    logic        expValid;
    logic        expReq;
    logic [31:0] expAddr;
    logic [31:0] expPc;
    logic [31:0] expIpc;
  } vecT;

  vecT vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 32'h%08h, want 32'h%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic redir, input logic [31:0] tgt, input logic rdy, input logic ack);
    bus.redirect_valid  = redir;
    bus.redirect_target = tgt;
    bus.instr_ready     = rdy;
    bus.imem_ack        = ack;
  endtask

  task automatic cycle(input logic redir, input logic [31:0] tgt, input logic rdy, input logic ack);
    drive(redir, tgt, rdy, ack);
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] expNext, prevAddr, prevInstr, prevIpc, tgt;
    logic        prevWait, prevHold, prevValid, redir, rdy, ack;
    int          idle;

    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    vecs[0] = '{1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0};
    vecs[1] = '{1'b0, 32'h0,     1'b1, 1'b1, 1'b0, 1'b1, 32'h0,   32'h0,   32'h0};
    vecs[2] = '{1'b0, 32'h0,     1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,   32'h0};
    vecs[3] = '{1'b0, 32'h0,     1'b1, 1'b1, 1'b0, 1'b1, 32'h4,   32'h4,   32'h0};
    vecs[4] = '{1'b0, 32'h0,     1'b1, 1'b0, 1'b1, 1'b0, 32'h4,   32'h4,   32'h4};
    vecs[5] = '{1'b0, 32'h0,     1'b1, 1'b1, 1'b0, 1'b1, 32'h8,   32'h8,   32'h4};
    vecs[6] = '{1'b1, 32'h100,   1'b1, 1'b0, 1'b1, 1'b0, 32'h8,   32'h8,   32'h8};
    vecs[7] = '{1'b0, 32'h0,     1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h100, 32'h8};
    vecs[8] = '{1'b0, 32'h0,     1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h100, 32'h100};
    vecs[9] = '{1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b1, 32'h104, 32'h104, 32'h100};

    doReset();
    check("reset_instr", bus.instr, 32'h0);
    check("reset_instr_pc", bus.instr_pc, 32'h0);

    // directed vectors: sequential fetch with same-cycle ack, then redirect on accept
    for (int i = 0; i < 10; i++) begin
      check($sformatf("vec%0d_valid", i), bus.instr_valid, vecs[i].expValid);
      check($sformatf("vec%0d_req", i), bus.imem_req, vecs[i].expReq);
      check($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].expAddr);
      check($sformatf("vec%0d_pc", i), bus.pc, vecs[i].expPc);
      if (vecs[i].expValid) begin
        check($sformatf("vec%0d_ipc", i), bus.instr_pc, vecs[i].expIpc);
        check($sformatf("vec%0d_instr", i), bus.instr, memWord(vecs[i].expIpc));
      end
      drive(vecs[i].redir, vecs[i].target, vecs[i].ready, vecs[i].ack);
      #1;
      check($sformatf("vec%0d_pc4", i), bus.pc_plus_four, vecs[i].expPc + 32'd4);
      check($sformatf("vec%0d_jump", i), bus.jump_amount, vecs[i].target);
      check($sformatf("vec%0d_sel", i), bus.select, vecs[i].redir);
      @(negedge clk);
    end

    // decode stall: everything held for 5 cycles
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check("stall_enter_valid", bus.instr_valid, 1'b1);
    check("stall_enter_ipc", bus.instr_pc, 32'h104);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      check("stall_valid", bus.instr_valid, 1'b1);
      check("stall_ipc", bus.instr_pc, 32'h104);
      check("stall_instr", bus.instr, memWord(32'h104));
      check("stall_pc", bus.pc, 32'h104);
      check("stall_req", bus.imem_req, 1'b0);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("stall_exit_addr", bus.imem_addr, 32'h108);

    // redirect while the fetch waits for ack
    cycle(1'b1, 32'h40, 1'b0, 1'b0);
    check("wait_redir_pc", bus.pc, 32'h40);
    check("wait_redir_addr", bus.imem_addr, 32'h108);
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      check("wait_hold_addr", bus.imem_addr, 32'h108);
      check("wait_hold_req", bus.imem_req, 1'b1);
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check("drop_valid", bus.instr_valid, 1'b0);
    check("drop_new_addr", bus.imem_addr, 32'h40);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check("redir_ipc", bus.instr_pc, 32'h40);
    check("redir_instr", bus.instr, memWord(32'h40));
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // wrap at the top of the address space
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    check("wrap_pc_load", bus.pc, 32'hFFFF_FFFC);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check("wrap_drop_addr", bus.imem_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check("wrap_ipc", bus.instr_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", bus.pc_plus_four, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("wrap_pc", bus.pc, 32'h0);
    check("wrap_addr", bus.imem_addr, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("pre_rst_pc", bus.pc, 32'h4);

    // reset mid-FETCH, then a late ack while IDLE
    rst = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    rst = 1'b0;
    check("midrst_pc", bus.pc, RESET_PC);
    check("midrst_req", bus.imem_req, 1'b0);
    check("midrst_valid", bus.instr_valid, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check("late_ack_valid", bus.instr_valid, 1'b0);
    check("late_ack_req", bus.imem_req, 1'b1);

    // misaligned redirect
    cycle(1'b1, 32'h42, 1'b0, 1'b0);
    check("misalign_pc", bus.pc, loadModel(32'h42));
`ifdef ALIGN_CHECK_EN
    check("addr_err_pulse", bus.addr_err, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("addr_err_clear", bus.addr_err, 1'b0);
`endif

    // randomized traffic against a transaction-level model
    doReset();
    expNext = RESET_PC; prevWait = 1'b0; prevHold = 1'b0; prevValid = 1'b0;
    prevAddr = 32'h0; prevInstr = 32'h0; prevIpc = 32'h0; idle = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (bus.instr_valid) begin
        if (!prevValid) begin
          check("rnd_ipc", bus.instr_pc, expNext);
          check("rnd_instr", bus.instr, memWord(bus.instr_pc));
          idle = 0;
        end
        check("rnd_pc_deliver", bus.pc, bus.instr_pc);
        check("rnd_req_deliver", bus.imem_req, 1'b0);
      end else begin
        check("rnd_pc", bus.pc, expNext);
      end
      if (prevWait) begin
        check("rnd_addr_hold", bus.imem_addr, prevAddr);
        check("rnd_req_hold", bus.imem_req, 1'b1);
      end
      if (prevHold) begin
        check("rnd_instr_hold", bus.instr, prevInstr);
        check("rnd_ipc_hold", bus.instr_pc, prevIpc);
      end
      idle++;
      if (idle > 150) begin
        compared++;
        mismatched++;
        $display("FAIL rnd_progress: got %0d idle cycles, want <= 150", idle);
        break;
      end
      redir = ($urandom_range(0, 9) == 0);
      tgt   = $urandom;
      rdy   = ($urandom_range(0, 3) != 0);
      ack   = bus.imem_req && ($urandom_range(0, 1) == 1);
      drive(redir, tgt, rdy, ack);
      prevWait  = bus.imem_req && !ack;
      prevAddr  = bus.imem_addr;
      prevHold  = bus.instr_valid && !rdy && !redir;
      prevValid = bus.instr_valid;
      prevInstr = bus.instr;
      prevIpc   = bus.instr_pc;
      if (redir) expNext = loadModel(tgt);
      else if (bus.instr_valid && rdy) expNext = bus.instr_pc + 32'd4;
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
